// File: rtl/vec_op_seq_if.sv
// Request/response bundle for vec_op_seq: operand request handshake in,
// registered three-component Q16.16 result handshake out.
interface vec_op_seq_if;
   logic               in_valid;
   logic               in_ready;
   logic        [2:0]  op;
   logic signed [31:0] a0, a1, a2;
   logic signed [31:0] b0, b1, b2;
   logic signed [31:0] s;
   logic               out_valid;
   logic               out_ready;
   logic signed [31:0] r0, r1, r2;
   logic               out_err;

   modport master (
      output in_valid, op, a0, a1, a2, b0, b1, b2, s, out_ready,
      input  in_ready, out_valid, r0, r1, r2, out_err
   );

   modport slave (
      input  in_valid, op, a0, a1, a2, b0, b1, b2, s, out_ready,
      output in_ready, out_valid, r0, r1, r2, out_err
   );
endinterface

// File: rtl/vec_op_seq.sv
// Q16.16 vector op sequencer (ADD/SUB/DOT/CROSS/SCALE) sharing one 32x32
// signed multiplier, one product per CALC cycle, registered result.
module vec_op_seq (
   input  logic        clk,
   input  logic        rst,
   vec_op_seq_if.slave bus
);
   localparam logic [2:0] OP_ADD   = 3'd0;
   localparam logic [2:0] OP_SUB   = 3'd1;
   localparam logic [2:0] OP_DOT   = 3'd2;
   localparam logic [2:0] OP_CROSS = 3'd3;
   localparam logic [2:0] OP_SCALE = 3'd4;

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

   // Arithmetic shift floors toward -inf; size casts wrap without saturation.
   function automatic logic signed [31:0] f_q16_trunc32(input logic signed [63:0] v);
      return 32'(v >>> 16);
   endfunction

   function automatic logic signed [47:0] f_q16_trunc48(input logic signed [63:0] v);
      return 48'(v >>> 16);
   endfunction

   state_t             r_state;
   logic        [2:0]  r_k;
   logic signed [63:0] r_acc;
   logic               r_out_valid;
   logic               r_out_err;
   logic signed [31:0] r_r0, r_r1, r_r2;

   logic        [2:0]  r_op;
   logic signed [31:0] r_a0, r_a1, r_a2, r_b0, r_b1, r_b2, r_s;

   logic signed [31:0] w_x, w_y;
   logic signed [63:0] w_p;
   logic        [2:0]  w_n;
   logic               w_last;
   logic signed [47:0] w_dot_acc;
   logic signed [31:0] w_scale_r;
   logic signed [31:0] w_cross_r;

   // Multiplier operand select for the current step.
   always_comb begin
      w_x = '0;
      w_y = '0;
      w_n = 3'd1;
      case (r_op)
         OP_DOT, OP_SCALE: begin
            w_n = 3'd3;
            case (r_k)
               3'd0:    begin w_x = r_a0; w_y = r_b0; end
               3'd1:    begin w_x = r_a1; w_y = r_b1; end
               default: begin w_x = r_a2; w_y = r_b2; end
            endcase
            if (r_op == OP_SCALE) w_y = r_s;
         end
         OP_CROSS: begin
            w_n = 3'd6;
            case (r_k)
               3'd0:    begin w_x = r_a1; w_y = r_b2; end
               3'd1:    begin w_x = r_a2; w_y = r_b1; end
               3'd2:    begin w_x = r_a2; w_y = r_b0; end
               3'd3:    begin w_x = r_a0; w_y = r_b2; end
               3'd4:    begin w_x = r_a0; w_y = r_b1; end
               default: begin w_x = r_a1; w_y = r_b0; end
            endcase
         end
         default: w_n = 3'd1;
      endcase
   end

   assign w_p       = 64'(w_x) * 64'(w_y);
   assign w_last    = (r_k == w_n - 3'd1);
   assign w_dot_acc = r_acc[47:0] + f_q16_trunc48(w_p);
   assign w_scale_r = f_q16_trunc32(w_p);
   assign w_cross_r = f_q16_trunc32(r_acc - w_p);

   // Operands are captured only on the accept edge.
   always_ff @(posedge clk) begin
      if (r_state == S_IDLE && bus.in_valid) begin
         r_op <= bus.op;
         r_a0 <= bus.a0; r_a1 <= bus.a1; r_a2 <= bus.a2;
         r_b0 <= bus.b0; r_b1 <= bus.b1; r_b2 <= bus.b2;
         r_s  <= bus.s;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_k         <= '0;
         r_acc       <= '0;
         r_out_valid <= 1'b0;
         r_out_err   <= 1'b0;
         r_r0        <= '0;
         r_r1        <= '0;
         r_r2        <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.in_valid) begin
                  r_state <= S_CALC;
                  r_k     <= '0;
                  r_acc   <= '0;
               end
            end
            S_CALC: begin
               case (r_op)
                  OP_ADD: begin
                     r_r0 <= r_a0 + r_b0;
                     r_r1 <= r_a1 + r_b1;
                     r_r2 <= r_a2 + r_b2;
                  end
                  OP_SUB: begin
                     r_r0 <= r_a0 - r_b0;
                     r_r1 <= r_a1 - r_b1;
                     r_r2 <= r_a2 - r_b2;
                  end
                  OP_DOT: begin
                     r_acc <= {{16{w_dot_acc[47]}}, w_dot_acc};
                     if (w_last) begin
                        r_r0 <= w_dot_acc[31:0];
                        r_r1 <= '0;
                        r_r2 <= '0;
                     end
                  end
                  OP_SCALE: begin
                     case (r_k)
                        3'd0:    r_r0 <= w_scale_r;
                        3'd1:    r_r1 <= w_scale_r;
                        default: r_r2 <= w_scale_r;
                     endcase
                  end
                  OP_CROSS: begin
                     // Even step holds the first product; odd step subtracts and shifts once.
                     if (!r_k[0]) begin
                        r_acc <= w_p;
                     end else begin
                        case (r_k[2:1])
                           2'd0:    r_r0 <= w_cross_r;
                           2'd1:    r_r1 <= w_cross_r;
                           default: r_r2 <= w_cross_r;
                        endcase
                     end
                  end
                  default: begin
                     r_r0 <= '0;
                     r_r1 <= '0;
                     r_r2 <= '0;
                  end
               endcase
               if (w_last) begin
                  r_state     <= S_DONE;
                  r_out_valid <= 1'b1;
                  r_out_err   <= (r_op > OP_SCALE);
               end else begin
                  r_k <= r_k + 3'd1;
               end
            end
            S_DONE: begin
               if (bus.out_ready) begin
                  r_state     <= S_IDLE;
                  r_out_valid <= 1'b0;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.in_ready  = (r_state == S_IDLE);
   assign bus.out_valid = r_out_valid;
   assign bus.out_err   = r_out_err;
   assign bus.r0        = r_r0;
   assign bus.r1        = r_r1;
   assign bus.r2        = r_r2;
endmodule

// File: tb/tb_vec_op_seq.sv
// Directed bench for vec_op_seq: latency, arithmetic results, backpressure,
// asynchronous reset mid-operation and illegal opcode handling.
module tb_vec_op_seq;
   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;

   vec_op_seq_if bus();

   vec_op_seq dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   task automatic chk_r(input string tag, input logic [31:0] e0, input logic [31:0] e1,
                        input logic [31:0] e2);
      chk({tag, "_r0"}, bus.r0, e0);
      chk({tag, "_r1"}, bus.r1, e1);
      chk({tag, "_r2"}, bus.r2, e2);
   endtask

   // Issue one request and walk exactly n edges, checking out_valid timing.
   task automatic run_op(input string tag, input logic [2:0] op,
                         input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] a2,
                         input logic [31:0] b0, input logic [31:0] b1, input logic [31:0] b2,
                         input logic [31:0] s, input int n);
      @(negedge clk);
      chk({tag, "_in_ready_idle"}, 32'(bus.in_ready), 32'd1);
      bus.op = op;
      bus.a0 = a0; bus.a1 = a1; bus.a2 = a2;
      bus.b0 = b0; bus.b1 = b1; bus.b2 = b2;
      bus.s  = s;
      bus.in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.a0 = 32'h0; bus.b0 = 32'h0; bus.op = 3'd0;
      chk({tag, "_in_ready_busy"}, 32'(bus.in_ready), 32'd0);
      for (int i = 1; i < n; i++) begin
         chk({tag, "_early_valid"}, 32'(bus.out_valid), 32'd0);
         @(posedge clk);
         @(negedge clk);
      end
      if (n > 1) chk({tag, "_early_valid"}, 32'(bus.out_valid), 32'd0);
      @(posedge clk);
      @(negedge clk);
      chk({tag, "_latency_valid"}, 32'(bus.out_valid), 32'd1);
   endtask

   task automatic finish_op(input string tag);
      bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.out_ready = 1'b0;
      chk({tag, "_valid_drop"}, 32'(bus.out_valid), 32'd0);
      chk({tag, "_in_ready_back"}, 32'(bus.in_ready), 32'd1);
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst = 1'b1;
      bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.op = 3'd0;
      bus.a0 = '0; bus.a1 = '0; bus.a2 = '0;
      bus.b0 = '0; bus.b1 = '0; bus.b2 = '0; bus.s = '0;
      repeat (2) @(negedge clk);
      chk("rst_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_err", 32'(bus.out_err), 32'd0);
      chk_r("rst", 32'h0, 32'h0, 32'h0);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

      // CROSS unit x by unit y gives unit z
      run_op("cross_xy", 3'd3, 32'h10000, 32'h0, 32'h0, 32'h0, 32'h10000, 32'h0, 32'h0, 6);
      chk_r("cross_xy", 32'h0, 32'h0, 32'h00010000);
      chk("cross_xy_err", 32'(bus.out_err), 32'd0);
      finish_op("cross_xy");

      // CROSS (1,2,3)x(4,5,6) = (-3,6,-3)
      run_op("cross_123", 3'd3, 32'h10000, 32'h20000, 32'h30000,
             32'h40000, 32'h50000, 32'h60000, 32'h0, 6);
      chk_r("cross_123", 32'hFFFD0000, 32'h00060000, 32'hFFFD0000);
      finish_op("cross_123");

      run_op("dot", 3'd2, 32'h10000, 32'h20000, 32'h30000,
             32'h40000, 32'h50000, 32'h60000, 32'h0, 3);
      chk_r("dot", 32'h00200000, 32'h0, 32'h0);
      chk("dot_err", 32'(bus.out_err), 32'd0);
      finish_op("dot");

      run_op("scale", 3'd4, 32'hFFFFFFFF, 32'hFFFE8000, 32'h7FFF0000,
             32'h11111111, 32'h22222222, 32'h33333333, 32'h8000, 3);
      chk_r("scale", 32'hFFFFFFFF, 32'hFFFF4000, 32'h3FFF8000);
      finish_op("scale");

      // Backpressure: result and state frozen while out_ready is low
      run_op("add_bp", 3'd0, 32'h10000, 32'h10000, 32'h10000,
             32'h8000, 32'h8000, 32'h8000, 32'h0, 1);
      chk_r("add_bp", 32'h18000, 32'h18000, 32'h18000);
      for (int i = 0; i < 5; i++) begin
         bus.in_valid = ~bus.in_valid;
         bus.a0 = bus.a0 + 32'h1234;
         bus.op = 3'd1;
         @(posedge clk);
         @(negedge clk);
         chk_r("bp_hold", 32'h18000, 32'h18000, 32'h18000);
         chk("bp_valid", 32'(bus.out_valid), 32'd1);
         chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
      end
      bus.in_valid = 1'b0;
      finish_op("add_bp");
      chk("bp_after_r0", bus.r0, 32'h18000);

      // Asynchronous reset during CROSS step 3
      run_op("pre_rst_dot", 3'd2, 32'h10000, 32'h0, 32'h0, 32'h10000, 32'h0, 32'h0, 32'h0, 3);
      finish_op("pre_rst_dot");
      @(negedge clk);
      bus.op = 3'd3;
      bus.a0 = 32'h10000; bus.a1 = 32'h20000; bus.a2 = 32'h30000;
      bus.b0 = 32'h40000; bus.b1 = 32'h50000; bus.b2 = 32'h60000;
      bus.in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("mid_cross_r0", bus.r0, 32'hFFFD0000);
      rst = 1'b1;
      #1;
      chk("rst_mid_valid", 32'(bus.out_valid), 32'd0);
      chk_r("rst_mid", 32'h0, 32'h0, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_mid_in_ready", 32'(bus.in_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      chk("rst_mid_no_result", 32'(bus.out_valid), 32'd0);

      run_op("sub", 3'd1, 32'h30000, 32'h0, 32'h0, 32'h10000, 32'h0, 32'h0, 32'h0, 1);
      chk("sub_r0", bus.r0, 32'h00020000);
      finish_op("sub");

      run_op("illegal", 3'd6, 32'h10000, 32'h10000, 32'h10000,
             32'h10000, 32'h10000, 32'h10000, 32'h10000, 1);
      chk_r("illegal", 32'h0, 32'h0, 32'h0);
      chk("illegal_err", 32'(bus.out_err), 32'd1);
      finish_op("illegal");

      run_op("add_after", 3'd0, 32'h10000, 32'h20000, 32'hFFFF0000,
             32'h10000, 32'h10000, 32'h10000, 32'h0, 1);
      chk_r("add_after", 32'h20000, 32'h30000, 32'h0);
      chk("add_after_err", 32'(bus.out_err), 32'd0);
      finish_op("add_after");

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
